vga_timing_ctrl: RTL and testbench

//   Run-control sequencer for the VGA scan datapath. Built from three counters:
//     - pixel prescaler;
//     - horizontal counter, enabled by the pixel tick;
//     - vertical counter, enabled by horizontal wrap.
//   A start/stop FSM gates the counters and only halts scanning on a frame boundary.

---
 rtl/vga_timing_ctrl.sv | 108 ++++++++++
 tb/tb_vga_timing_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA scan sequencer: pixel prescaler, h/v counters and a start/stop FSM that halts only on a frame boundary.
// Counters and state are registered. The sync, video and strobe decodes are combinational and forced inactive in IDLE.
module vga_timing_ctrl #(
    parameter int DIV    = 4,
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int HW     = 10,
    parameter int VW     = 10
) (
    input  logic          clk,
    input  logic          i_arst,
    input  logic          i_start,
    input  logic          i_stop,
    output logic          o_busy,
    output logic          o_pix_en,
    output logic [HW-1:0] o_hcnt,
    output logic [VW-1:0] o_vcnt,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_video_on,
    output logic          o_line_end,
    output logic          o_frame_start
);
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;

    logic busy, pix_en, h_last, v_last;

    assign busy   = (state_q != S_IDLE);
    assign pix_en = busy && (presc_q == PW'(DIV - 1));
    assign h_last = (hcnt_q == HW'(H_TOTAL - 1));
    assign v_last = (vcnt_q == VW'(V_TOTAL - 1));

    // Stop beats start everywhere; a cancel in STOPPING wins over the frame-end exit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_start && !i_stop) state_d = S_RUN;
            S_RUN:  if (i_stop) state_d = S_STOP;
            S_STOP: begin
                if (i_start && !i_stop)
                    state_d = S_RUN;
                else if (pix_en && h_last && v_last)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d = '0;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        if (busy) begin
            presc_d = pix_en ? '0 : presc_q + PW'(1);
            if (pix_en) begin
                hcnt_d = h_last ? '0 : hcnt_q + HW'(1);
                if (h_last)
                    vcnt_d = v_last ? '0 : vcnt_q + VW'(1);
            end
        end else begin
            hcnt_d = '0;
            vcnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

    assign o_busy        = busy;
    assign o_pix_en      = pix_en;
    assign o_hcnt        = hcnt_q;
    assign o_vcnt        = vcnt_q;
    assign o_hsync       = !(busy && (hcnt_q >= HW'(H_DISP + H_FP)) &&
                             (hcnt_q <= HW'(H_DISP + H_FP + H_SYNC - 1)));
    assign o_vsync       = !(busy && (vcnt_q >= VW'(V_DISP + V_FP)) &&
                             (vcnt_q <= VW'(V_DISP + V_FP + V_SYNC - 1)));
    assign o_video_on    = busy && (hcnt_q < HW'(H_DISP)) && (vcnt_q < VW'(V_DISP));
    assign o_line_end    = pix_en && h_last;
    assign o_frame_start = pix_en && (hcnt_q == '0) && (vcnt_q == '0);
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl with a small 14x7 raster; the reference tracks clocks elapsed in the current frame.
module tb_vga_timing_ctrl;
    localparam int DIV = 2;
    localparam int HD = 8, HF = 2, HS = 2, HB = 2;
    localparam int VD = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME = DIV * HT * VT;

    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic       busy, pix_en, hsync, vsync, video_on, line_end, frame_start;
    logic [9:0] hcnt, vcnt;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int m_state = 0;  // 0 idle, 1 run, 2 stopping
    int m_c = 0;      // clocks elapsed since the start of the current frame
    int t0, t1;

    vga_timing_ctrl #(
        .DIV(DIV), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HW(10), .VW(10)
    ) dut (
        .clk(clk), .i_arst(rst), .i_start(start), .i_stop(stop),
        .o_busy(busy), .o_pix_en(pix_en), .o_hcnt(hcnt), .o_vcnt(vcnt),
        .o_hsync(hsync), .o_vsync(vsync), .o_video_on(video_on),
        .o_line_end(line_end), .o_frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int m_h();
        return (m_c / DIV) % HT;
    endfunction

    function automatic int m_v();
        return (m_c / DIV) / HT;
    endfunction

    task automatic check_all();
        int b, p, h, v;
        b = (m_state != 0) ? 1 : 0;
        p = (b == 1 && (m_c % DIV) == DIV - 1) ? 1 : 0;
        h = b ? m_h() : 0;
        v = b ? m_v() : 0;
        chk("busy", int'(busy), b);
        chk("pix_en", int'(pix_en), p);
        chk("hcnt", int'(hcnt), h);
        chk("vcnt", int'(vcnt), v);
        chk("hsync", int'(hsync), (b == 1 && h >= HD + HF && h < HD + HF + HS) ? 0 : 1);
        chk("vsync", int'(vsync), (b == 1 && v >= VD + VF && v < VD + VF + VS) ? 0 : 1);
        chk("video_on", int'(video_on), (b == 1 && h < HD && v < VD) ? 1 : 0);
        chk("line_end", int'(line_end), (p == 1 && h == HT - 1) ? 1 : 0);
        chk("frame_start", int'(frame_start), (p == 1 && h == 0 && v == 0) ? 1 : 0);
    endtask

    task automatic model_step();
        int nxt;
        if (rst) begin
            m_state = 0;
            m_c = 0;
        end else begin
            nxt = m_state;
            if (m_state == 0 && start && !stop) nxt = 1;
            else if (m_state == 1 && stop) nxt = 2;
            else if (m_state == 2 && start && !stop) nxt = 1;
            else if (m_state == 2 && m_c == FRAME - 1) nxt = 0;
            m_c = (m_state != 0) ? (m_c + 1) % FRAME : 0;
            m_state = nxt;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_all();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Start latency: busy right after the sampling edge, first tick one cycle later.
        start = 1'b1;
        cycle();
        chk("t1_busy", int'(busy), 1);
        chk("t1_no_tick", int'(pix_en), 0);
        start = 1'b0;
        cycle();
        chk("t1_first_tick", int'(pix_en), 1);
        chk("t1_frame_start", int'(frame_start), 1);
        t0 = cyc;

        // Free run: frame period.
        t1 = 0;
        for (int i = 0; i < 2 * FRAME && t1 == 0; i++) begin
            cycle();
            if (frame_start) t1 = cyc;
        end
        chk("t2_frame_period", t1 - t0, FRAME);

        // Stop mid-frame: scan finishes the frame, then idles.
        for (int i = 0; i < 2 * FRAME && !(m_v() == 2 && m_state == 1); i++) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        for (int i = 0; i < 2 * FRAME && m_state != 0; i++) cycle();
        chk("t3_idle_busy", int'(busy), 0);
        chk("t3_idle_hsync", int'(hsync), 1);
        cycle();
        chk("t3_idle_hold", int'(hcnt), 0);

        // Stop then cancel before the frame ends: no gap in frame timing.
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        t0 = cyc;
        repeat (40) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        repeat (20) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        t1 = 0;
        for (int i = 0; i < 2 * FRAME && t1 == 0; i++) begin
            cycle();
            if (frame_start) t1 = cyc;
        end
        chk("t4_cancel_period", t1 - t0, FRAME);

        // Start and stop together: ignored in IDLE, stays STOPPING.
        stop = 1'b1;
        for (int i = 0; i < 2 * FRAME && m_state != 0; i++) cycle();
        start = 1'b1;
        repeat (5) cycle();
        chk("t5_idle_both", int'(busy), 0);
        stop = 1'b0;
        cycle();
        start = 1'b0;
        repeat (10) cycle();
        stop = 1'b1;
        cycle();
        start = 1'b1;
        repeat (6) cycle();
        chk("t5_stopping_both", int'(busy), 1);
        start = 1'b0;
        stop = 1'b0;
        repeat (3) cycle();

        // Async reset mid-line, then a clean restart.
        for (int i = 0; i < 2 * FRAME && !(m_h() == 5 && m_state != 0); i++) cycle();
        #2;
        rst = 1'b1;
        #1;
        m_state = 0;
        m_c = 0;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_hcnt", int'(hcnt), 0);
        chk("t6_rst_video", int'(video_on), 0);
        check_all();
        cycle();
        rst = 1'b0;
        cycle();
        start = 1'b1;
        cycle();
        chk("t6_restart_busy", int'(busy), 1);
        chk("t6_restart_no_tick", int'(pix_en), 0);
        start = 1'b0;
        cycle();
        chk("t6_restart_tick", int'(pix_en), 1);
        chk("t6_restart_fs", int'(frame_start), 1);

        // Random start/stop/reset traffic against the reference.
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 39) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            rst   = ($urandom_range(0, 1499) == 0);
            cycle();
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
